display_mode_sequencer: RTL and testbench
=========================================

# display_mode_sequencer

Control block for the display datapath. It selects the active `display_mode` (spectrum / SPL / BPM / mixed) from a debounced front-panel key or an auto-rotate dwell timer. It paces the display controller's `enable` with a refresh-rate strobe that fires only once fresh source data for the current mode has arrived. It also provides a hold (freeze) function and a stale-data flag. It sits between the analysis blocks (FFT, SPL, BPM), the panel keys, and the display controller.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a key must be stable before its debounced level changes (20 ms at 50 MHz).
- `DWELL_CYCLES`, default 150_000_000: auto-rotate dwell per mode (3 s).
- `REFRESH_CYCLES`, default 5_000_000: refresh tick period (10 Hz).
- `STALE_TICKS`, default 8: consecutive refresh ticks without an update before `stale` is raised.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `key_next_n` in 1: raw mode key, active-low, asynchronous.
- `key_hold_n` in 1: raw hold key, active-low, asynchronous.
- `auto_en` in 1: level input; 1 enables auto-rotation.
- `fft_valid` in 1: one-cycle pulse marking a new FFT frame.
- `spl_valid` in 1: one-cycle pulse marking a new SPL value.
- `bpm_valid` in 1: one-cycle pulse marking a new BPM value.
- `display_mode` out 3: 0 = spectrum, 1 = SPL, 2 = BPM, 3 = mixed. Values 4–7 are never driven.
- `disp_enable` out 1: one-cycle update strobe to the display controller `enable`.
- `mode_changed` out 1: one-cycle pulse in the first cycle the new `display_mode` is visible.
- `hold_active` out 1: level; 1 while the display is frozen.
- `stale` out 1: level; 1 while the current mode's data has gone stale.

## Operation
- **Reset values:**
  - `display_mode` = 0; `disp_enable`, `mode_changed`, `hold_active`, `stale` = 0.
  - Debounced key levels = 1 (released).
  - All counters and freshness flags = 0.
- **Key path (each key):**
  - 2-FF synchronizer, then debounce counter.
  - The counter increments while the synced value differs from the debounced level and clears otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced value and the counter clears.
  - A press event is a registered 1→0 transition of the debounced level.
  - Releases generate no event.
- **Mode register:**
  - Increments modulo 4 (3→0) on a next-key press or an auto-advance.
  - If both occur in the same cycle, it increments once.
  - A next-key press while held also clears `hold_active`.
- **Hold:** a hold-key press toggles `hold_active`.
- **Dwell counter:**
  - Counts only while `auto_en`=1 and `hold_active`=0; otherwise it freezes.
  - Clears when `auto_en`=0 and on every mode change.
  - Issues an auto-advance when it reaches `DWELL_CYCLES-1`.
- **Freshness flags `f_fft`, `f_spl`, `f_bpm`:**
  - Each is set by its valid pulse.
  - All three clear on a mode change.
  - Required set per mode: mode 0 = {fft}, mode 1 = {spl}, mode 2 = {bpm}, mode 3 = {fft, spl}.
- **Update FSM, states IDLE → ARMED → PULSE:**
  - IDLE: waits until every required flag is set (the current-cycle valid pulse counts), then moves to ARMED.
  - ARMED: on a refresh tick, moves to PULSE if `hold_active`=0; stays in ARMED while held.
  - PULSE: `disp_enable`=1 for one cycle and the required flags clear. If a valid pulse arrives in this cycle, set wins over clear. Returns to IDLE.
  - A mode change in any state forces IDLE, and no pulse is issued that cycle.
- **Refresh counter:** free-running 0..`REFRESH_CYCLES-1`; the tick occurs at the terminal count.
- **Stale counter:**
  - Counts refresh ticks since the last `disp_enable`, saturating at `STALE_TICKS`.
  - `stale` = (count == `STALE_TICKS`).
  - Clears on `disp_enable` or a mode change.
  - Does not count while `hold_active`=1.
- Reset asserted mid-operation returns every register to its reset value on the next edge. A key held low through reset registers no press until it has been released and pressed again.

## Timing
- Raw key falling edge, held stable → `display_mode` and `mode_changed` update exactly `DEBOUNCE_CYCLES`+3 cycles later:
  - 2 cycles synchronizer;
  - `DEBOUNCE_CYCLES` debounce;
  - 1 cycle event register.
- Dwell terminal count in cycle N → new `display_mode` in cycle N+1.
- Refresh tick in cycle N with FSM in ARMED → `disp_enable` high in cycle N+1 only.
- Minimum spacing between `disp_enable` pulses: `REFRESH_CYCLES`.
- All outputs are registered. No combinational input-to-output paths.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DWELL_CYCLES`=100, `REFRESH_CYCLES`=10, `STALE_TICKS`=3.

1. **Debounce:** press `key_next_n` for 3 cycles, then release → no mode change. Press and hold for 10 cycles → `display_mode` 0→1, with `mode_changed` pulsing 7 cycles after the edge. Four such presses wrap the mode 3→0.
2. **Auto-rotate:** `auto_en`=1, no keys → the mode advances every 100 cycles (0,1,2,3,0). `auto_en`=0 → the mode stays constant. A key press and the dwell terminal count in the same cycle → the mode increments once.
3. **Gating:**
   - Mode 3: `fft_valid` only → no `disp_enable` for 50 cycles.
   - Then `spl_valid` → exactly one `disp_enable`, in the cycle after the next tick.
4. **Hold:**
   - Hold press → `hold_active`=1; no `disp_enable` and no auto-advance despite valid pulses.
   - Second hold press → pulses resume.
   - A next-key press while held → the mode advances and `hold_active`=0.
5. **Stale:** mode 2 with no `bpm_valid` → `stale`=1 after the 3rd tick. Then `bpm_valid` → `disp_enable` and `stale`=0.
6. **Reset mid-operation:** `rst`=1 during a PULSE/debounce sequence → all outputs reach their reset values on the next edge. With `key_next_n` held low through reset → no press event until release and re-press.

Source files
------------

// File: rtl/display_mode_sequencer.sv
// Display mode selection (key / auto-rotate), freshness-gated refresh strobe,
// hold (freeze) control and stale-data flag for the display controller.
module display_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DWELL_CYCLES    = 150_000_000,
  parameter int unsigned REFRESH_CYCLES  = 5_000_000,
  parameter int unsigned STALE_TICKS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_next_n,
  input  logic       key_hold_n,
  input  logic       auto_en,
  input  logic       fft_valid,
  input  logic       spl_valid,
  input  logic       bpm_valid,
  output logic [2:0] display_mode,
  output logic       disp_enable,
  output logic       mode_changed,
  output logic       hold_active,
  output logic       stale
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DwW = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned RfW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned StW = $clog2(STALE_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StPulse} upd_state_e;

  logic [1:0] key_raw;
  logic [1:0] press_ev;

  assign key_raw = {key_hold_n, key_next_n};

  // Index 0 = next key, 1 = hold key.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic           sync1_q, sync2_q, deb_q, deb_d, seen_rel_q, press_q;
    logic [DbW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Synchronizer resets to "pressed" so a key held through reset must be
    // seen released before any press can be reported.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b1;
        cnt_q      <= '0;
        seen_rel_q <= 1'b0;
        press_q    <= 1'b0;
      end else begin
        sync1_q    <= key_raw[k];
        sync2_q    <= sync1_q;
        deb_q      <= deb_d;
        cnt_q      <= cnt_d;
        seen_rel_q <= seen_rel_q | sync2_q;
        press_q    <= seen_rel_q & deb_q & ~deb_d;
      end
    end

    assign press_ev[k] = press_q;
  end

  logic           next_press, hold_press, auto_adv, adv, tick;
  logic [1:0]     mode_q, mode_d;
  logic           hold_q, hold_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [RfW-1:0] ref_q, ref_d;
  logic [StW-1:0] stale_cnt_q, stale_cnt_d;
  logic [2:0]     fresh_q, fresh_d, valid_vec, req, flag_clr;
  logic           req_met, pulse_d;
  logic           disp_enable_q, mode_changed_q, stale_q;
  upd_state_e     state_q, state_d;

  assign next_press = press_ev[0];
  assign hold_press = press_ev[1];
  assign valid_vec  = {bpm_valid, spl_valid, fft_valid};
  assign auto_adv   = auto_en & ~hold_q & (dwell_q == DwW'(DWELL_CYCLES - 1));
  assign adv        = next_press | auto_adv;
  assign tick       = (ref_q == RfW'(REFRESH_CYCLES - 1));

  always_comb begin
    hold_d = hold_q;
    if (hold_q) begin
      if (next_press || hold_press) hold_d = 1'b0;
    end else if (hold_press) begin
      hold_d = 1'b1;
    end
    mode_d  = adv ? mode_q + 2'd1 : mode_q;
    dwell_d = dwell_q;
    if (!auto_en || adv) begin
      dwell_d = '0;
    end else if (!hold_q) begin
      dwell_d = dwell_q + 1'b1;
    end
    ref_d = tick ? '0 : ref_q + 1'b1;
  end

  always_comb begin
    case (mode_q)
      2'd0:    req = 3'b001;
      2'd1:    req = 3'b010;
      2'd2:    req = 3'b100;
      default: req = 3'b011;
    endcase
  end

  // Current-cycle valid pulses count towards readiness.
  assign req_met = (((fresh_q | valid_vec) & req) == req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (req_met) state_d = StArmed;
        StArmed: if (tick && !hold_q) state_d = StPulse;
        StPulse: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pulse_d  = (state_d == StPulse);
    flag_clr = (state_q == StPulse) ? req : 3'b000;
    // A valid arriving during the pulse cycle survives the clear.
    fresh_d  = adv ? 3'b000 : ((fresh_q & ~flag_clr) | valid_vec);
    stale_cnt_d = stale_cnt_q;
    if (adv || pulse_d) begin
      stale_cnt_d = '0;
    end else if (tick && !hold_q && (stale_cnt_q != StW'(STALE_TICKS))) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= 2'd0;
      hold_q         <= 1'b0;
      dwell_q        <= '0;
      ref_q          <= '0;
      stale_cnt_q    <= '0;
      fresh_q        <= 3'b000;
      disp_enable_q  <= 1'b0;
      mode_changed_q <= 1'b0;
      stale_q        <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      hold_q         <= hold_d;
      dwell_q        <= dwell_d;
      ref_q          <= ref_d;
      stale_cnt_q    <= stale_cnt_d;
      fresh_q        <= fresh_d;
      disp_enable_q  <= pulse_d;
      mode_changed_q <= adv;
      stale_q        <= (stale_cnt_d == StW'(STALE_TICKS));
    end
  end

  assign display_mode = {1'b0, mode_q};
  assign disp_enable  = disp_enable_q;
  assign mode_changed = mode_changed_q;
  assign hold_active  = hold_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the mode/refresh/stale rules.
module tb_display_mode_sequencer;

  localparam int D = 4;
  localparam int W = 100;
  localparam int R = 10;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_next_n = 1'b1;
  logic       key_hold_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       fft_valid = 1'b0;
  logic       spl_valid = 1'b0;
  logic       bpm_valid = 1'b0;
  logic [2:0] display_mode;
  logic       disp_enable, mode_changed, hold_active, stale;

  always #5 clk = ~clk;

  display_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .DWELL_CYCLES   (W),
    .REFRESH_CYCLES (R),
    .STALE_TICKS    (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_next_n  (key_next_n),
    .key_hold_n  (key_hold_n),
    .auto_en     (auto_en),
    .fft_valid   (fft_valid),
    .spl_valid   (spl_valid),
    .bpm_valid   (bpm_valid),
    .display_mode(display_mode),
    .disp_enable (disp_enable),
    .mode_changed(mode_changed),
    .hold_active (hold_active),
    .stale       (stale)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int n_changes = 0;

  // Reference model state
  int       m_mode, m_dwell, m_cyc, m_stale_cnt;
  bit       m_hold, m_changed, m_pulse, m_rdy, m_stale;
  bit [2:0] m_fresh;
  bit       m_s1[2], m_s2[2], m_deb[2], m_seen[2], m_press[2];
  int       m_run[2];

  function automatic bit [2:0] req_of(input int md);
    case (md)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  task automatic model_step();
    bit       raw[2];
    bit       pn, ph, adv, tick, nxt_pulse, nd;
    bit [2:0] v, rq;
    raw[0] = key_next_n;
    raw[1] = key_hold_n;
    v = {bpm_valid, spl_valid, fft_valid};
    if (rst) begin
      m_mode = 0; m_dwell = 0; m_cyc = 0; m_stale_cnt = 0;
      m_hold = 0; m_changed = 0; m_pulse = 0; m_rdy = 0; m_stale = 0; m_fresh = 0;
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 1; m_seen[k] = 0; m_press[k] = 0; m_run[k] = 0;
      end
      return;
    end
    tick = ((m_cyc % R) == R - 1);
    m_cyc++;
    pn = m_press[0];
    ph = m_press[1];
    for (int k = 0; k < 2; k++) begin
      nd = m_deb[k];
      if (m_s2[k] != m_deb[k]) begin
        if (m_run[k] + 1 == D) begin
          nd = m_s2[k];
          m_run[k] = 0;
        end else begin
          m_run[k]++;
        end
      end else begin
        m_run[k] = 0;
      end
      m_press[k] = m_seen[k] && m_deb[k] && !nd;
      m_seen[k] = m_seen[k] || m_s2[k];
      m_deb[k] = nd;
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    adv = pn || (auto_en && !m_hold && m_dwell == W - 1);
    rq = req_of(m_mode);
    nxt_pulse = 0;
    if (adv) begin
      m_rdy = 0;
      m_fresh = 0;
    end else if (m_pulse) begin
      m_rdy = 0;
      m_fresh = (m_fresh & ~rq) | v;
    end else begin
      if (!m_rdy) begin
        m_rdy = (((m_fresh | v) & rq) == rq);
      end else if (tick && !m_hold) begin
        nxt_pulse = 1;
        m_rdy = 0;
      end
      m_fresh = m_fresh | v;
    end
    m_pulse = nxt_pulse;
    if (adv || nxt_pulse) m_stale_cnt = 0;
    else if (tick && !m_hold && m_stale_cnt < S) m_stale_cnt++;
    m_stale = (m_stale_cnt == S);
    if (!auto_en || adv) m_dwell = 0;
    else if (!m_hold) m_dwell++;
    if (m_hold) m_hold = !(pn || ph);
    else m_hold = ph;
    if (adv) m_mode = (m_mode + 1) % 4;
    m_changed = adv;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("display_mode", 8'(display_mode), 8'(m_mode));
    chk("disp_enable", 8'(disp_enable), 8'(m_pulse));
    chk("mode_changed", 8'(mode_changed), 8'(m_changed));
    chk("hold_active", 8'(hold_active), 8'(m_hold));
    chk("stale", 8'(stale), 8'(m_stale));
    if (disp_enable === 1'b1) n_pulses++;
    if (mode_changed === 1'b1) n_changes++;
  endtask

  task automatic press(input int k);
    if (k == 0) key_next_n = 1'b0;
    else key_hold_n = 1'b0;
    repeat (10) step();
    key_next_n = 1'b1;
    key_hold_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic goto_mode(input int md);
    for (int g = 0; g < 8 && m_mode != md; g++) press(0);
  endtask

  int exp_mode;
  int kcnt[2];

  initial begin
    // Reset
    repeat (3) step();
    chk("reset_mode", 8'(display_mode), 8'd0);
    chk("reset_enable", 8'(disp_enable), 8'd0);
    rst = 1'b0;
    repeat (3) step();

    // Debounce: short press ignored
    n_changes = 0;
    key_next_n = 1'b0;
    repeat (3) step();
    key_next_n = 1'b1;
    repeat (12) step();
    chk("short_press", 8'(n_changes), 8'd0);

    // Debounce: held press, change visible 7 cycles after the edge
    key_next_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) chk("mc_early", 8'(mode_changed), 8'd0);
      if (i == 7) begin
        chk("mc_latency", 8'(mode_changed), 8'd1);
        chk("mode_after_press", 8'(display_mode), 8'd1);
      end
    end
    key_next_n = 1'b1;
    repeat (10) step();
    repeat (3) press(0);
    chk("mode_wrap", 8'(display_mode), 8'd0);

    // Auto-rotate every W cycles
    auto_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (W) step();
      chk("auto_mode", 8'(display_mode), 8'((i + 1) % 4));
      chk("auto_mc", 8'(mode_changed), 8'd1);
    end
    auto_en = 1'b0;
    n_changes = 0;
    repeat (150) step();
    chk("auto_off", 8'(n_changes), 8'd0);

    // Key press event coincides with dwell terminal count
    auto_en = 1'b1;
    repeat (W - D - 3) step();
    n_changes = 0;
    key_next_n = 1'b0;
    repeat (10) step();
    key_next_n = 1'b1;
    repeat (20) step();
    chk("coincide_once", 8'(n_changes), 8'd1);
    chk("coincide_mode", 8'(display_mode), 8'd1);
    auto_en = 1'b0;

    // Gating in mixed mode
    goto_mode(3);
    repeat (5) step();
    fft_valid = 1'b1;
    step();
    fft_valid = 1'b0;
    n_pulses = 0;
    repeat (50) step();
    chk("gate_fft_only", 8'(n_pulses), 8'd0);
    spl_valid = 1'b1;
    step();
    spl_valid = 1'b0;
    repeat (25) step();
    chk("gate_one_pulse", 8'(n_pulses), 8'd1);

    // Hold freezes pulses and auto-rotation
    press(1);
    chk("hold_on", 8'(hold_active), 8'd1);
    auto_en = 1'b1;
    n_pulses = 0;
    n_changes = 0;
    for (int i = 0; i < 150; i++) begin
      fft_valid = ($urandom_range(0, 3) == 0);
      spl_valid = ($urandom_range(0, 3) == 0);
      bpm_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    {fft_valid, spl_valid, bpm_valid} = 3'b000;
    chk("hold_no_pulse", 8'(n_pulses), 8'd0);
    chk("hold_no_adv", 8'(n_changes), 8'd0);
    press(1);
    chk("hold_off", 8'(hold_active), 8'd0);
    n_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      fft_valid = ($urandom_range(0, 2) == 0);
      spl_valid = ($urandom_range(0, 2) == 0);
      bpm_valid = ($urandom_range(0, 2) == 0);
      step();
    end
    {fft_valid, spl_valid, bpm_valid} = 3'b000;
    chk("hold_resume", 8'(n_pulses > 0), 8'd1);
    auto_en = 1'b0;
    press(1);
    exp_mode = (m_mode + 1) % 4;
    press(0);
    chk("next_clears_hold", 8'(hold_active), 8'd0);
    chk("next_while_held", 8'(display_mode), 8'(exp_mode));

    // Stale in BPM mode
    goto_mode(2);
    repeat (35) step();
    chk("stale_set", 8'(stale), 8'd1);
    bpm_valid = 1'b1;
    n_pulses = 0;
    step();
    bpm_valid = 1'b0;
    repeat (12) step();
    chk("stale_pulse", 8'(n_pulses), 8'd1);
    chk("stale_clear", 8'(stale), 8'd0);

    // Random traffic
    kcnt[0] = 0;
    kcnt[1] = 0;
    for (int i = 0; i < 2000; i++) begin
      fft_valid = ($urandom_range(0, 5) == 0);
      spl_valid = ($urandom_range(0, 5) == 0);
      bpm_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      for (int k = 0; k < 2; k++) begin
        if (kcnt[k] > 0) kcnt[k]--;
        else if ($urandom_range(0, 99) == 0) kcnt[k] = $urandom_range(2, 12);
      end
      key_next_n = (kcnt[0] == 0);
      key_hold_n = (kcnt[1] == 0);
      step();
    end
    key_next_n = 1'b1;
    key_hold_n = 1'b1;
    {fft_valid, spl_valid, bpm_valid} = 3'b000;
    auto_en = 1'b0;
    repeat (20) step();

    // Reset mid-operation with a key debouncing and the update path armed
    {fft_valid, spl_valid, bpm_valid} = 3'b111;
    step();
    {fft_valid, spl_valid, bpm_valid} = 3'b000;
    key_next_n = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_mode", 8'(display_mode), 8'd0);
    chk("rst_enable", 8'(disp_enable), 8'd0);
    chk("rst_mc", 8'(mode_changed), 8'd0);
    chk("rst_hold", 8'(hold_active), 8'd0);
    chk("rst_stale", 8'(stale), 8'd0);
    rst = 1'b0;
    n_changes = 0;
    repeat (30) step();
    chk("held_through_rst", 8'(n_changes), 8'd0);
    key_next_n = 1'b1;
    repeat (10) step();
    press(0);
    chk("repress_after_rst", 8'(display_mode), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
